// File: rtl/store_monitor.sv
// Observer on the CPU data-memory write bus: logs stores into a show-ahead FIFO and
// decides run/pass/fail. Define STORE_MONITOR_TIMEOUT_EN to build the watchdog.
module store_monitor #(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] PASS_ADDR   = 32'd60,
    parameter logic [31:0] PASS_DATA   = 32'd28,
    parameter logic [31:0] IGNORE_ADDR = 32'd80,
    parameter logic [15:0] TIMEOUT     = 16'd1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [31:0]                dataadr,
    input  logic [31:0]                writedata,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [31:0]                rd_addr,
    output logic [31:0]                rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       done,
    output logic                       pass,
    output logic                       timed_out
);
    // state | meaning
    // RUN   | program running, no verdict yet
    // PASS  | pass store seen; terminal until reset
    // FAIL  | unexpected store or watchdog expiry; terminal until reset
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] PASS = 2'd1;
    localparam logic [1:0] FAIL = 2'd2;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    state, state_nxt;
    logic          to_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic          full, empty, pop, push_ok, drop;
    logic          pass_hit, deciding;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = rd_en && !empty;
    assign push_ok = memwrite && (!full || pop);
    assign drop    = memwrite && full && !pop;

    assign rd_valid = !empty;
    assign rd_addr  = empty ? 32'd0 : mem_addr[rd_ptr];
    assign rd_data  = empty ? 32'd0 : mem_data[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: empty reads are masked to zero above.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[wr_ptr] <= dataadr;
            mem_data[wr_ptr] <= writedata;
        end
    end

    assign pass_hit = (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
    assign deciding = memwrite && (pass_hit || (dataadr != IGNORE_ADDR));

`ifdef STORE_MONITOR_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        wd_hit;

    assign wd_hit = (wd_cnt == (TIMEOUT - 16'd1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_cnt <= '0;
        else if (state == RUN)
            wd_cnt <= wd_cnt + 16'd1;
    end
`else
    logic wd_hit;
    logic unused_timeout;

    assign wd_hit         = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_nxt = state;
        to_nxt    = timed_out;
        if (state == RUN) begin
            if (deciding) begin
                state_nxt = pass_hit ? PASS : FAIL;
            end else if (wd_hit) begin
                state_nxt = FAIL;
                to_nxt    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            done      <= 1'b0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            done      <= (state_nxt != RUN);
            pass      <= (state_nxt == PASS);
            timed_out <= to_nxt;
        end
    end
endmodule

// File: tb/tb_store_monitor.sv
// Scoreboard bench for store_monitor; watchdog cases run when STORE_MONITOR_TIMEOUT_EN is defined.
module tb_store_monitor;
    localparam int          DEPTH = 8;
    localparam logic [15:0] TMO   = 16'd20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_addr, rd_data;
    logic [3:0]  count;
    logic        overflow, done, pass, timed_out;

    int total = 0;
    int bad = 0;

    // model state
    logic [63:0] q[$];
    int          m_state;  // 0 run, 1 pass, 2 fail
    logic        m_ovf, m_to;
    int          m_wd;

    store_monitor #(
        .DEPTH(DEPTH), .PASS_ADDR(32'd60), .PASS_DATA(32'd28),
        .IGNORE_ADDR(32'd80), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .count(count),
        .overflow(overflow), .done(done), .pass(pass), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0;
        m_ovf   = 1'b0;
        m_to    = 1'b0;
        m_wd    = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".valid"}, 64'(rd_valid), 64'(q.size() != 0));
        chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".done"}, 64'(done), 64'(m_state != 0));
        chk({tag, ".pass"}, 64'(pass), 64'(m_state == 1));
        chk({tag, ".to"}, 64'(timed_out), 64'(m_to));
        if (q.size() != 0) chk({tag, ".head"}, {rd_addr, rd_data}, q[0]);
        else               chk({tag, ".head0"}, {rd_addr, rd_data}, 64'd0);
    endtask

    // Called at a negedge; drives one cycle, updates the model, returns at the next negedge.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic re, input string tag);
        logic        pop_ok;
        logic [63:0] exp_head;
        memwrite  = we;
        dataadr   = a;
        writedata = d;
        rd_en     = re;
        pop_ok    = re && (q.size() != 0);
        if (pop_ok) begin
            exp_head = q.pop_front();
            chk({tag, ".pop"}, {rd_addr, rd_data}, exp_head);
        end
        if (we) begin
            if (q.size() < DEPTH || pop_ok) q.push_back({a, d});
            else m_ovf = 1'b1;
        end
        if (m_state == 0) begin
            if (we && a == 32'd60 && d == 32'd28) m_state = 1;
            else if (we && a != 32'd80) m_state = 2;
`ifdef STORE_MONITOR_TIMEOUT_EN
            else if (m_wd == int'(TMO) - 1) begin
                m_state = 2;
                m_to    = 1'b1;
            end
            m_wd++;
`endif
        end
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        rd_en    = 1'b0;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #2;
        check_all("rst");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("por");
        reset = 1'b1;

        // pass path, then drain in order
        step(1, 80, 7, 0, "p1");
        step(1, 80, 3, 0, "p2");
        step(1, 60, 28, 0, "p3");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "pdrain");
        step(0, 0, 0, 1, "pempty");

        // fail path; later pass store is logged but verdict holds
        do_reset();
        step(1, 84, 7, 0, "f1");
        step(1, 60, 28, 0, "f2");

        // wrong pass data
        do_reset();
        step(1, 60, 27, 0, "wd");

        // overflow, full push+pop, drain, empty push+pop
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 80, 32'(i + 1), 0, "ovf");
        step(1, 80, 100, 1, "fullpp");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, "odrain");
        step(1, 80, 55, 1, "emptypp");

        // asynchronous reset mid-run
        do_reset();
        step(1, 80, 1, 0, "m1");
        step(1, 80, 2, 0, "m2");
        step(1, 80, 3, 0, "m3");
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async");
        #1;
        reset = 1'b1;
        step(1, 60, 28, 0, "mpass");

`ifdef STORE_MONITOR_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < int'(TMO); i++) step(0, 0, 0, 0, "wdog");
        chk("wdog.fired", 64'(timed_out), 64'd1);
        do_reset();
        for (int i = 0; i < int'(TMO) - 1; i++) step(0, 0, 0, 0, "wrun");
        step(1, 60, 28, 0, "wprio");
        chk("wprio.pass", 64'(pass), 64'd1);
`else
        do_reset();
        for (int i = 0; i < 30; i++) step(0, 0, 0, 0, "idle");
        chk("idle.done", 64'(done), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/store_monitor.md
# store_monitor

Downstream observer on the single-cycle MIPS data-memory write bus (memwrite, dataadr, writedata), attached in parallel with dmem. It logs every CPU store into a show-ahead FIFO and runs a verdict state machine: done/pass on the programmed pass store, fail on any unexpected store or a watchdog timeout. Benches and the board harness use it as the single source of truth for program-completion status, in place of ad-hoc negedge checks.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..256.
- PASS_ADDR, 32'd60: store address that ends the run successfully.
- PASS_DATA, 32'd28: data required at PASS_ADDR for a pass.
- IGNORE_ADDR, 32'd80: scratch address; stores here never change the verdict.
- TIMEOUT, 16'd1000: watchdog limit in cycles (only with STORE_MONITOR_TIMEOUT_EN).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  1  CPU store strobe, sampled on the rising edge.
- dataadr  in  32  store byte address.
- writedata  in  32  store data.
- rd_en  in  1  pop the FIFO head; ignored when rd_valid=0.
- rd_valid  out  1  FIFO non-empty.
- rd_addr  out  32  head entry address (show-ahead).
- rd_data  out  32  head entry data.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a store was dropped because the FIFO was full.
- done  out  1  verdict reached (PASS or FAIL state).
- pass  out  1  verdict is pass; valid only while done=1.
- timed_out  out  1  FAIL was caused by the watchdog; tied 0 when the watchdog is compiled out.

## Operation
- States: RUN, PASS, FAIL. Reset enters RUN.
- In RUN, a store sampled with memwrite=1:
  - dataadr==PASS_ADDR and writedata==PASS_DATA → PASS.
  - dataadr==IGNORE_ADDR → stay in RUN.
  - Any other store, including PASS_ADDR with wrong data → FAIL.
- PASS and FAIL are terminal until reset. Later stores never change the verdict but are still logged.
- Logging: every sampled store, including the verdict-causing one, is pushed as {dataadr, writedata}.
  - If the FIFO is full with no pop in the same cycle, the store is dropped and overflow sets. The verdict logic still evaluates the store.
  - Full FIFO with a simultaneous push and pop: both take effect; count stays at DEPTH; no drop.
  - Empty FIFO with a simultaneous push and pop: the pop is ignored; the push lands; count becomes 1.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full/empty are derived from count.
- Outputs: pass=(state==PASS); done=(state!=RUN). Both are registered state decodes.

## Timing
- Reset values: state RUN, count 0, pointers 0, overflow 0, done 0, pass 0, timed_out 0, rd_valid 0. rd_addr and rd_data read as 0 while empty.
- Reset asserted mid-run clears everything immediately, asynchronously; FIFO contents are discarded.
- Verdict latency: done and pass update on the same rising edge that samples the deciding store, so they are visible one cycle after that store's address phase.
- FIFO latency: a store pushed on edge N gives rd_valid=1 after edge N. rd_en sampled high on edge M advances the head after edge M.
- count and overflow are updated on the same edge as the push or pop.

## Configuration
- STORE_MONITOR_TIMEOUT_EN defined: a 16-bit cycle counter starts at 0 on reset release and increments each cycle in RUN.
  - When the counter equals TIMEOUT-1 in RUN with no deciding store that cycle, the block moves to FAIL and sets timed_out=1.
  - A deciding store in the same cycle takes priority over the timeout.
  - The counter freezes once the state leaves RUN.
- STORE_MONITOR_TIMEOUT_EN undefined: no counter is built, timed_out is constant 0, and the block can stay in RUN indefinitely.

## Test plan
- Pass path: stores (80,7), (80,3), (60,28) on consecutive cycles → done=1, pass=1 after the third edge; count=3; FIFO pops in order (80,7), (80,3), (60,28).
- Fail path: store (84,7) → done=1, pass=0 after that edge. A subsequent (60,28) leaves pass=0 and is logged (count=2).
- Wrong pass data: store (60,27) → FAIL.
- Overflow with DEPTH=8: ten stores to 80 with no pops → count=8, overflow=1, head=(80, first data). Then push and pop in the same cycle while full → count stays 8 and overflow does not re-trigger.
- Mid-run reset: after 3 logged stores, pulse reset low between edges → count, done and overflow read 0 immediately. Then (60,28) → pass=1.
- Watchdog (macro defined, TIMEOUT=20): no stores for 20 cycles → done=1, pass=0, timed_out=1 at edge 20. Rerun with (60,28) on cycle 20 → pass=1, timed_out=0.
